// File: rtl/imem_stream_loader.sv
// Parses a length-prefixed, XOR-checksummed byte stream into instruction-memory writes; core held in reset until verified.
// One byte per cycle; each assembled word costs one extra WRITE cycle with s_ready low; all outputs registered.
module imem_stream_loader #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              init_mode,
    output logic              write_enable,
    output logic [ADDR_W-1:0] init_address,
    output logic [31:0]       init_instruction,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      len_hi;
    logic [15:0]     n_len;
    logic [15:0]     len_full;
    logic [ADDR_W:0] word_idx, idx_inc;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;
    logic [7:0]      csum;
    logic [TW-1:0]   idle_cnt;
    logic            accept, receiving, timed_out;
    logic            loading_nxt, ready_nxt;

    assign accept    = s_valid && s_ready;
    assign len_full  = {len_hi, s_data};
    assign idx_inc   = word_idx + 1'b1;
    assign receiving = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign timed_out = receiving && !s_valid && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        loading_nxt = 1'b0;
        ready_nxt   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (32'(len_full) > MAX_WORDS) state_nxt = S_ERROR;
                    else if (len_full == 16'd0)    state_nxt = S_CSUM;
                    else                           state_nxt = S_DATA;
                end
            end
            S_DATA:  if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (32'(idx_inc) == 32'(n_len)) ? S_CSUM : S_DATA;
            S_CSUM:  if (accept) state_nxt = (s_data == csum) ? S_DONE : S_ERROR;
        endcase
        if (timed_out) state_nxt = S_ERROR;

        // Outputs are registered from the next state so they line up with the state register.
        ready_nxt   = (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                      (state_nxt == S_DATA)   || (state_nxt == S_CSUM);
        loading_nxt = ready_nxt || (state_nxt == S_WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_ready      <= 1'b0;
            init_mode    <= 1'b0;
            write_enable <= 1'b0;
            core_reset   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            s_ready      <= ready_nxt;
            init_mode    <= loading_nxt;
            write_enable <= (state_nxt == S_WRITE);
            core_reset   <= (state_nxt != S_DONE);
            busy         <= loading_nxt;
            done         <= (state_nxt == S_DONE);
            error        <= (state_nxt == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi           <= '0;
            n_len            <= '0;
            word_idx         <= '0;
            byte_cnt         <= '0;
            word_buf         <= '0;
            csum             <= '0;
            idle_cnt         <= '0;
            init_address     <= '0;
            init_instruction <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        csum         <= '0;
                        word_idx     <= '0;
                        byte_cnt     <= '0;
                        idle_cnt     <= '0;
                        init_address <= '0;
                    end
                end
                S_LEN_HI: if (accept) len_hi <= s_data;
                S_LEN_LO: if (accept) n_len <= len_full;
                S_DATA: begin
                    if (accept) begin
                        word_buf <= {word_buf[15:0], s_data};
                        csum     <= csum ^ s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            init_address     <= word_idx[ADDR_W-1:0];
                            init_instruction <= {word_buf, s_data};
                        end
                    end
                end
                S_WRITE: word_idx <= idx_inc;
                default: ;
            endcase

            // Idle counter runs only while waiting on the stream; WRITE leaves it frozen.
            if (receiving) begin
                if (s_valid) idle_cnt <= '0;
                else         idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: directed vector table, timeout/reset/boundary sequences, randomized frames.
module tb_imem_stream_loader;
    localparam int ADDR_W = 12;
    localparam int TO     = 16;
    localparam int MAXW   = 4096;

    logic              clk = 1'b0;
    logic              reset, start, s_valid, s_ready;
    logic [7:0]        s_data;
    logic              init_mode, write_enable, core_reset, busy, done, error;
    logic [ADDR_W-1:0] init_address;
    logic [31:0]       init_instruction;

    always #5 clk = ~clk;

    imem_stream_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .init_mode(init_mode), .write_enable(write_enable),
        .init_address(init_address), .init_instruction(init_instruction),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    typedef struct {
        string       name;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          bad;
        bit          exp_done;
        int          exp_wr;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          viol     = 0;
    wr_t         got[$];
    logic [31:0] words[MAXW];
    vec_t        tbl[6];

    // Write monitor: every strobe is logged; a strobe while s_ready is high or outside a load is a violation.
    always @(negedge clk) begin
        if (write_enable) begin
            got.push_back('{a: init_address, d: init_instruction});
            if (s_ready || !init_mode || !busy) viol++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) tick();
        end
        s_data  = b;
        s_valid = 1'b1;
        n       = 0;
        @(negedge clk);
        while (!s_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout byte=%0h never accepted", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string name, input int n, input bit bad, input int mingap,
                        input int maxgap, input bit exp_done, input int exp_wr);
        logic [7:0]  cs;
        logic [15:0] n16;
        logic [31:0] w;
        int          k, bad_wr, lim;
        cs  = 8'h00;
        n16 = 16'(n);
        got.delete();
        viol = 0;
        pulse_start();
        check({name, "_busy_at_start"}, 64'(busy), 64'd1);
        send_byte(n16[15:8], $urandom_range(maxgap, mingap));
        send_byte(n16[7:0], $urandom_range(maxgap, mingap));
        if (n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                w = words[i];
                for (int b = 3; b >= 0; b--) begin
                    cs = cs ^ w[8*b +: 8];
                    send_byte(w[8*b +: 8], $urandom_range(maxgap, mingap));
                end
            end
            send_byte(bad ? (cs ^ 8'h01) : cs, $urandom_range(maxgap, mingap));
        end
        s_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!(done || error) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 64'(done), 64'(exp_done));
        check({name, "_error"}, 64'(error), 64'(!exp_done));
        check({name, "_core_reset"}, 64'(core_reset), 64'(!exp_done));
        check({name, "_init_mode"}, 64'(init_mode), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_write_count"}, 64'(got.size()), 64'(exp_wr));
        check({name, "_strobe_violations"}, 64'(viol), 64'd0);
        bad_wr = 0;
        lim = (got.size() < exp_wr) ? got.size() : exp_wr;
        for (int i = 0; i < lim; i++)
            if (got[i].a !== ADDR_W'(i) || got[i].d !== words[i]) bad_wr++;
        check({name, "_write_content_errors"}, 64'(bad_wr), 64'd0);
        tick();
    endtask

    task automatic fill_row(input int r);
        words[0] = tbl[r].w0;
        words[1] = tbl[r].w1;
        for (int i = 2; i < 8; i++) words[i] = tbl[r].w0 + 32'(i);
    endtask

    initial begin
        int  n;
        bit  bad;
        tbl[0] = '{"t1_n2_ok",     2,    32'h20080005, 32'h00000000, 1'b0, 1'b1, 2};
        tbl[1] = '{"t2_n2_badcs",  2,    32'h20080005, 32'h00000000, 1'b1, 1'b0, 2};
        tbl[2] = '{"t3_n4097",     4097, 32'h0,        32'h0,        1'b0, 1'b0, 0};
        tbl[3] = '{"n0_ok",        0,    32'h0,        32'h0,        1'b0, 1'b1, 0};
        tbl[4] = '{"n1_ok",        1,    32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1};
        tbl[5] = '{"n3_badcs",     3,    32'h01234567, 32'h89ABCDEF, 1'b1, 1'b0, 3};

        reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_init_mode", 64'(init_mode), 64'd0);
        check("rst_write_enable", 64'(write_enable), 64'd0);
        check("rst_init_address", 64'(init_address), 64'd0);
        check("rst_init_instruction", 64'(init_instruction), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_status", 64'({busy, done, error}), 64'd0);
        reset = 1'b1;
        tick();

        // Directed vectors with s_valid held high, so bytes stall across every WRITE cycle.
        for (int r = 0; r < 6; r++) begin
            fill_row(r);
            load(tbl[r].name, tbl[r].n, tbl[r].bad, 0, 0, tbl[r].exp_done, tbl[r].exp_wr);
        end

        // Timeout: error must appear exactly at the edge ending the 16th idle cycle.
        got.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        s_valid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check("timeout_not_early", 64'(error), 64'd0);
        @(negedge clk);
        check("timeout_error", 64'(error), 64'd1);
        check("timeout_no_writes", 64'(got.size()), 64'd0);
        check("timeout_core_reset", 64'(core_reset), 64'd1);
        tick();

        // Gaps one short of the timeout must never abort.
        words[0] = 32'hCAFEF00D;
        load("gap15_ok", 1, 1'b0, TO - 1, TO - 1, 1'b1, 1);

        // Reset asserted during a WRITE cycle, then the first frame reloaded.
        words[0] = 32'h12345678;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int b = 3; b >= 0; b--) send_byte(words[0][8*b +: 8], 0);
        s_valid = 1'b0;
        check("midload_we_high", 64'(write_enable), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midload_rst_we", 64'(write_enable), 64'd0);
        check("midload_rst_instr", 64'(init_instruction), 64'd0);
        check("midload_rst_outputs", 64'({s_ready, init_mode, busy, done, error, core_reset}), 64'b000001);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        fill_row(0);
        load("after_reset_t1", 2, 1'b0, 0, 0, 1'b1, 2);

        // Largest legal image: addresses 0..4095, no wrap.
        for (int i = 0; i < MAXW; i++) words[i] = $urandom;
        load("n4096_full", MAXW, 1'b0, 0, 0, 1'b1, MAXW);

        for (int t = 0; t < 25; t++) begin
            n   = ($urandom_range(7, 0) == 0) ? (MAXW + 1 + $urandom_range(200, 0)) : $urandom_range(8, 0);
            bad = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < 8; i++) words[i] = $urandom;
            load($sformatf("rand%0d", t), n, bad, 0, 3, (n <= MAXW) && !bad, (n <= MAXW) ? n : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
